// File: rtl/rtc_bus_ctrl.sv
// Two-phase bus-cycle engine for the external RTC muxed address/data port.
// Optional write-verify readback: define RTC_WRITE_VERIFY_EN.
module rtc_bus_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 8,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       verify_err,
    inout  wire  [7:0] DATA_ADDRESS,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ASU  = 4'd1;
    localparam logic [3:0] S_APL  = 4'd2;
    localparam logic [3:0] S_AHD  = 4'd3;
    localparam logic [3:0] S_GAP  = 4'd4;
    localparam logic [3:0] S_DSU  = 4'd5;
    localparam logic [3:0] S_DPL  = 4'd6;
    localparam logic [3:0] S_DHD  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic [7:0] C_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] C_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] C_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] C_GAP   = 8'(T_GAP - 1);

`ifdef RTC_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic [3:0] state, nstate;
    logic [7:0] cnt, ncnt;
    logic       rd_op, nrd;
    logic       vfy, nvfy;
    logic       vgap, nvgap;
    logic [7:0] addr_q, naddr;
    logic [7:0] wdata_q, nwdata;
    logic       bus_oe;
    logic [7:0] bus_q;
    logic       last, na, nd;

    assign DATA_ADDRESS = bus_oe ? bus_q : 8'bz;

    always_comb begin
        nstate = state;
        nrd    = rd_op;
        nvfy   = vfy;
        nvgap  = vgap;
        naddr  = addr_q;
        nwdata = wdata_q;
        last   = (cnt == 8'd0);
        case (state)
            S_IDLE: if (req) begin
                nstate = S_ASU;
                nrd    = ~we;
                nvfy   = 1'b0;
                nvgap  = 1'b0;
                naddr  = addr;
                nwdata = wdata;
            end
            S_ASU: if (last) nstate = S_APL;
            S_APL: if (last) nstate = S_AHD;
            S_AHD: if (last) nstate = S_GAP;
            // a gap following a verified write leads back into a fresh address phase
            S_GAP: if (last) begin
                nstate = vgap ? S_ASU : S_DSU;
                nvgap  = 1'b0;
            end
            S_DSU: if (last) nstate = S_DPL;
            S_DPL: if (last) nstate = S_DHD;
            S_DHD: if (last) begin
                if (VERIFY && !rd_op) begin
                    nstate = S_GAP;
                    nrd    = 1'b1;
                    nvfy   = 1'b1;
                    nvgap  = 1'b1;
                end else begin
                    nstate = S_DONE;
                end
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase

        ncnt = cnt;
        if (nstate != state) begin
            case (nstate)
                S_ASU, S_DSU: ncnt = C_SETUP;
                S_APL, S_DPL: ncnt = C_PULSE;
                S_AHD, S_DHD: ncnt = C_HOLD;
                S_GAP:        ncnt = C_GAP;
                default:      ncnt = 8'd0;
            endcase
        end else if (!last) begin
            ncnt = cnt - 8'd1;
        end

        na = (nstate == S_ASU) || (nstate == S_APL) || (nstate == S_AHD);
        nd = (nstate == S_DSU) || (nstate == S_DPL) || (nstate == S_DHD);
    end

    // pins are decoded from the next state so every strobe comes straight off a flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            rd_op      <= 1'b0;
            vfy        <= 1'b0;
            vgap       <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            bus_oe     <= 1'b0;
            bus_q      <= 8'd0;
            ChipSelect <= 1'b1;
            Read       <= 1'b1;
            Write      <= 1'b1;
            AoD        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 8'd0;
            verify_err <= 1'b0;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            rd_op      <= nrd;
            vfy        <= nvfy;
            vgap       <= nvgap;
            addr_q     <= naddr;
            wdata_q    <= nwdata;
            ChipSelect <= !(na || nd);
            AoD        <= !na;
            Write      <= !((nstate == S_APL) || ((nstate == S_DPL) && !nrd));
            Read       <= !((nstate == S_DPL) && nrd);
            bus_oe     <= na || (nd && !nrd);
            bus_q      <= na ? naddr : nwdata;
            busy       <= (nstate != S_IDLE);
            done       <= (nstate == S_DONE);
            if ((state == S_DPL) && rd_op && last)
                rdata <= DATA_ADDRESS;
            if (nstate == S_DONE)
                verify_err <= vfy && (rdata != wdata_q);
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: per-cycle pin trace expected from the bus-cycle rules,
// with a bus model answering reads. Define RTC_WRITE_VERIFY_EN to cover readback.
module tb_rtc_bus_ctrl;
    localparam int T_SETUP = 2;
    localparam int T_PULSE = 8;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 4;
`ifdef RTC_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, verify_err;
    wire  [7:0] DATA_ADDRESS;
    logic       ChipSelect, Read, Write, AoD;

    logic [7:0] model_val = 8'h00;
    assign DATA_ADDRESS = (Read == 1'b0) ? model_val : 8'bz;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_verr  = 1'b0;

    typedef struct packed {
        logic       cs, aod, rd, wr, oe, dn;
        logic [7:0] bus;
    } ent_t;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    rtc_bus_ctrl #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .verify_err(verify_err),
        .DATA_ADDRESS(DATA_ADDRESS), .ChipSelect(ChipSelect), .Read(Read),
        .Write(Write), .AoD(AoD)
    );

    // one phase of the RTC cycle: setup, strobe pulse, hold, with CS low throughout
    task automatic push_phase(input bit is_addr, input bit is_read, input logic [7:0] v);
        int n = T_SETUP + T_PULSE + T_HOLD;
        for (int i = 0; i < n; i++) begin
            ent_t e;
            bit pulse = (i >= T_SETUP) && (i < T_SETUP + T_PULSE);
            e.cs  = 1'b0;
            e.aod = !is_addr;
            e.oe  = is_addr || !is_read;
            e.rd  = !(pulse && !is_addr && is_read);
            e.wr  = !(pulse && (is_addr || !is_read));
            e.dn  = 1'b0;
            e.bus = e.oe ? v : 8'h00;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n, input bit dn);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, dn, 8'h00});
    endtask

    task automatic build(input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_q.delete();
        push_phase(1'b1, !w, a);
        push_idle(T_GAP, 1'b0);
        push_phase(1'b0, !w, d);
        if (VERIFY && w) begin
            push_idle(T_GAP, 1'b0);
            push_phase(1'b1, 1'b1, a);
            push_idle(T_GAP, 1'b0);
            push_phase(1'b0, 1'b1, 8'h00);
        end
        push_idle(1, 1'b1);
    endtask

    // drives one transaction from IDLE and checks every cycle up to and including the following IDLE
    task automatic run_txn(input string nm, input bit w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] mv, input bit keep, input int poke);
        logic [6:0] obs, exp;
        build(w, a, d);
        if (!w || VERIFY) exp_rdata = mv;
        exp_verr = (VERIFY && w) ? (mv != d) : 1'b0;
        model_val = mv;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs = {ChipSelect, AoD, Read, Write, dut.bus_oe, done, busy};
            exp = {exp_q[i].cs, exp_q[i].aod, exp_q[i].rd, exp_q[i].wr, exp_q[i].oe, exp_q[i].dn, 1'b1};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s pins cyc%0d got %b exp %b (cs aod rd wr oe done busy)", nm, i + 1, obs, exp);
            end
            if (exp_q[i].oe) begin
                tests++;
                if (DATA_ADDRESS !== exp_q[i].bus) begin
                    fails++;
                    $display("FAIL %s bus cyc%0d got %h exp %h", nm, i + 1, DATA_ADDRESS, exp_q[i].bus);
                end
            end
            if (exp_q[i].dn) begin
                tests++;
                if (rdata !== exp_rdata || verify_err !== exp_verr) begin
                    fails++;
                    $display("FAIL %s done rdata/verr got %h/%b exp %h/%b", nm, rdata, verify_err, exp_rdata, exp_verr);
                end
            end
            if (i == 0) begin
                if (!keep) req = 1'b0;
                we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
            end
            if (i == poke) begin req = 1'b1; addr = ~a; we = ~w; end
            if (poke >= 0 && i == poke + 1) req = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || ChipSelect !== 1'b1 || rdata !== exp_rdata || verify_err !== exp_verr) begin
            fails++;
            $display("FAIL %s idle busy/done/cs/rdata/verr got %b/%b/%b/%h/%b exp 0/0/1/%h/%b",
                     nm, busy, done, ChipSelect, rdata, verify_err, exp_rdata, exp_verr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({ChipSelect, Read, Write, AoD, dut.bus_oe, busy, done, verify_err} !== 8'b11110000 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset pins got %b rdata %h exp 11110000 rdata 00",
                     {ChipSelect, Read, Write, AoD, dut.bus_oe, busy, done, verify_err}, rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || ChipSelect !== 1'b1) begin
            fails++;
            $display("FAIL reset_release busy/cs got %b/%b exp 0/1", busy, ChipSelect);
        end
    endtask

    task automatic test_write;      run_txn("write", 1'b1, 8'h23, 8'h21, 8'h21, 1'b0, -1); endtask
    task automatic test_read;       run_txn("read",  1'b0, 8'h24, 8'h00, 8'h45, 1'b0, -1); endtask
    task automatic test_ignore_req; run_txn("ignore", 1'b1, 8'h31, 8'h5a, 8'h5a, 1'b0, 4); endtask

    task automatic test_back_to_back;
        run_txn("b2b0", 1'b1, 8'h10, 8'h11, 8'h11, 1'b1, -1);
        run_txn("b2b1", 1'b0, 8'h12, 8'h00, 8'h9c, 1'b1, -1);
        run_txn("b2b2", 1'b1, 8'h14, 8'h15, 8'h15, 1'b0, -1);
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        req = 1'b1; we = 1'b1; addr = 8'h33; wdata = 8'h44;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) req = 1'b0;
        end
        tests++;
        if (Write !== 1'b0 || AoD !== 1'b1 || DATA_ADDRESS !== 8'h44) begin
            fails++;
            $display("FAIL rst_mid dpulse wr/aod/bus got %b/%b/%h exp 0/1/44", Write, AoD, DATA_ADDRESS);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({ChipSelect, Read, Write, AoD, dut.bus_oe, busy, done} !== 7'b1111000) begin
            fails++;
            $display("FAIL rst_mid pins got %b exp 1111000", {ChipSelect, Read, Write, AoD, dut.bus_oe, busy, done});
        end
        reset = 1'b1;
        exp_rdata = 8'h00; exp_verr = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_mid no_done got %0d busy/done cycles exp 0", seen);
        end
    endtask

    task automatic test_verify;
        run_txn("verify_bad", 1'b1, 8'h40, 8'h59, 8'h58, 1'b0, -1);
        run_txn("verify_ok",  1'b1, 8'h40, 8'h59, 8'h59, 1'b0, -1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++)
            run_txn("random", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    (n < 7) ? 1'($urandom) : 1'b0, -1);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_ignore_req;
        test_reset_mid;
        test_verify;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
